// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags.
// The decoder reads rs1/rs2 through combinational query ports. Each query
// returns either the committed value or the ROB id that will produce it.
// A decoder issue marks rd busy with its ROB id. A ROB commit writes the
// value and clears busy, but only when the tag still matches. A rollback
// drops every rename so the decoder restarts from architectural state.
//
// Handshake semantics: issue_valid and commit_valid are single-cycle
// qualifiers with no back-pressure. A transfer takes effect at the rising
// clk edge where its valid is high and rdy is high. A valid seen while
// rdy is low is lost; the producer must hold it until a cycle with rdy=1.
module reg_file #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int ROB_WIDTH = 4,
  parameter int IDX_W     = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic [IDX_W-1:0]     issue_rd,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  input  logic                 commit_valid,
  input  logic [IDX_W-1:0]     commit_rd,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [XLEN-1:0]      commit_value,
  input  logic [IDX_W-1:0]     rs1_idx,
  output logic [XLEN-1:0]      rs1_value,
  output logic                 rs1_busy,
  output logic [ROB_WIDTH-1:0] rs1_rob_id,
  input  logic [IDX_W-1:0]     rs2_idx,
  output logic [XLEN-1:0]      rs2_value,
  output logic                 rs2_busy,
  output logic [ROB_WIDTH-1:0] rs2_rob_id
);

  logic [XLEN-1:0]      value_q [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_q   [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;

  logic commit_en;
  logic issue_en;

  // x0 is hardwired, so any write that targets it is dropped here once.
  assign commit_en = commit_valid && (commit_rd != '0);
  assign issue_en  = issue_valid && (issue_rd != '0) && !rollback;

  // State update. The assignment order sets the priority: rollback first,
  // then the commit, then the issue. A same-cycle issue to the same rd
  // therefore overrides the busy clear done by the commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        busy_q <= '0;
      end
      if (commit_en) begin
        value_q[commit_rd] <= commit_value;
        // A newer rename of this rd keeps it busy under its new tag.
        if (tag_q[commit_rd] == commit_rob_id) begin
          busy_q[commit_rd] <= 1'b0;
        end
      end
      if (issue_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_id;
      end
    end
  end

  // Source 1 query. A commit that retires the pending producer is
  // forwarded in the same cycle. A same-cycle issue is not forwarded.
  always_comb begin
    rs1_value  = '0;
    rs1_busy   = 1'b0;
    rs1_rob_id = '0;
    if (rst && (rs1_idx != '0)) begin
      rs1_value  = value_q[rs1_idx];
      rs1_busy   = busy_q[rs1_idx];
      rs1_rob_id = tag_q[rs1_idx];
      if (commit_valid && (commit_rd == rs1_idx) && busy_q[rs1_idx] &&
          (tag_q[rs1_idx] == commit_rob_id)) begin
        rs1_value = commit_value;
        rs1_busy  = 1'b0;
      end
    end
  end

  // Source 2 query, identical to source 1.
  always_comb begin
    rs2_value  = '0;
    rs2_busy   = 1'b0;
    rs2_rob_id = '0;
    if (rst && (rs2_idx != '0)) begin
      rs2_value  = value_q[rs2_idx];
      rs2_busy   = busy_q[rs2_idx];
      rs2_rob_id = tag_q[rs2_idx];
      if (commit_valid && (commit_rd == rs2_idx) && busy_q[rs2_idx] &&
          (tag_q[rs2_idx] == commit_rob_id)) begin
        rs2_value = commit_value;
        rs2_busy  = 1'b0;
      end
    end
  end

endmodule
